// File: rtl/spmv_gather.sv
// Gathers x[col] for each beat of (col, value) pairs via one parallel vector-RAM read, re-pairing
// the returned words with their values; a credit-limited FIFO absorbs the fixed RAM read latency.
module spmv_gather #(
  parameter int PARALLELISM = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int LENGTH      = 1024,
  parameter int ADDR_WIDTH  = $clog2(LENGTH),
  parameter int RAM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0]     in_idx,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]     in_val,
  input  logic                                       in_last,
  output logic                                       ram_valid,
  output logic                                       ram_write,
  output logic [PARALLELISM-1:0][ADDR_WIDTH-1:0]     ram_addr,
  input  logic                                       ram_ready,
  input  logic                                       ram_rvalid,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]     ram_rdata,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]     out_val,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]     out_x,
  output logic                                       out_last,
  output logic                                       err_oob
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LEN = (ADDR_WIDTH + 1)'(LENGTH);

  typedef logic [PARALLELISM-1:0][DATA_WIDTH-1:0] lanes_t;
  typedef struct packed {
    lanes_t                 val;
    logic [PARALLELISM-1:0] oob;
    logic                   last;
  } side_t;
  typedef struct packed {
    lanes_t val;
    lanes_t x;
    logic   last;
  } entry_t;

  logic [PARALLELISM-1:0] oob;
  logic                   fire, push, pop;
  logic [CW-1:0]          fifo_count, inflight;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  side_t                  side_q [RAM_LATENCY];
  entry_t                 wr_entry, head;
  entry_t                 mem [FIFO_DEPTH];

  // Credit covers both buffered beats and reads still in the RAM, so a response always has a slot.
  assign in_ready  = rst_n && (({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH));
  assign fire      = in_valid && in_ready && ram_ready;
  assign ram_valid = fire;
  assign ram_write = 1'b0;
  assign push      = ram_rvalid && (inflight != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    oob      = '0;
    ram_addr = '0;
    for (int j = 0; j < PARALLELISM; j++) begin
      oob[j]      = ({1'b0, in_idx[j]} >= LEN);
      ram_addr[j] = oob[j] ? '0 : in_idx[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RAM_LATENCY; s++) side_q[s] <= '0;
    end else begin
      side_q[0] <= fire ? '{val: in_val, oob: oob, last: in_last} : '0;
      for (int s = 1; s < RAM_LATENCY; s++) side_q[s] <= side_q[s-1];
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.val  = side_q[RAM_LATENCY-1].val;
    wr_entry.last = side_q[RAM_LATENCY-1].last;
    for (int j = 0; j < PARALLELISM; j++)
      wr_entry.x[j] = side_q[RAM_LATENCY-1].oob[j] ? '0 : ram_rdata[j];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      err_oob    <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      inflight   <= inflight + CW'(fire) - CW'(push);
      if (fire && (|oob)) err_oob <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_count != '0);
  assign out_val   = out_valid ? head.val  : '0;
  assign out_x     = out_valid ? head.x    : '0;
  assign out_last  = out_valid ? head.last : 1'b0;

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    ram_rvalid |-> (inflight != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (fifo_count != CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_spmv_gather.sv
// Bench for spmv_gather: directed vector table plus randomized streams against a queue-based model,
// on two instances (latency 1 / depth 4 and latency 3 / depth 5) selected through a shared driver.
module tb_spmv_gather;
  localparam int LEN = 1000;
  localparam int LA  = 1;
  localparam int LB  = 3;

  typedef logic [3:0][31:0] lanes_t;
  typedef logic [3:0][9:0]  idx_t;
  typedef struct {
    lanes_t val;
    lanes_t x;
    logic   last;
  } exp_t;
  typedef struct {
    idx_t   idx;
    lanes_t val;
    logic   last;
    lanes_t x;
    idx_t   addr;
    logic   err;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  logic   sel = 1'b0;
  logic   in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  idx_t   in_idx = '0;
  lanes_t in_val = '0;

  logic   a_in_valid, a_in_ready, a_ram_valid, a_ram_write, a_ram_rvalid, a_out_valid, a_out_ready, a_out_last, a_err;
  logic   b_in_valid, b_in_ready, b_ram_valid, b_ram_write, b_ram_rvalid, b_out_valid, b_out_ready, b_out_last, b_err;
  idx_t   a_ram_addr, b_ram_addr;
  lanes_t a_ram_rdata, b_ram_rdata, a_out_val, b_out_val, a_out_x, b_out_x;

  logic   in_ready, ram_valid, ram_write, out_valid, out_last, err_oob;
  idx_t   ram_addr;
  lanes_t out_val, out_x;

  logic [31:0] xmem [LEN];
  exp_t        sbq [$];
  exp_t        mon_e;
  int          checks = 0, errors = 0;
  int          accepts = 0, pops = 0, infl = 0, max_infl = 0, max_out = 0;
  logic        model_err = 1'b0;

  always #5 clk = ~clk;

  spmv_gather #(.PARALLELISM(4), .DATA_WIDTH(32), .LENGTH(LEN), .RAM_LATENCY(LA), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_idx(in_idx),
    .in_val(in_val), .in_last(in_last), .ram_valid(a_ram_valid), .ram_write(a_ram_write),
    .ram_addr(a_ram_addr), .ram_ready(1'b1), .ram_rvalid(a_ram_rvalid), .ram_rdata(a_ram_rdata),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_val(a_out_val), .out_x(a_out_x),
    .out_last(a_out_last), .err_oob(a_err));

  spmv_gather #(.PARALLELISM(4), .DATA_WIDTH(32), .LENGTH(LEN), .RAM_LATENCY(LB), .FIFO_DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(in_idx),
    .in_val(in_val), .in_last(in_last), .ram_valid(b_ram_valid), .ram_write(b_ram_write),
    .ram_addr(b_ram_addr), .ram_ready(1'b1), .ram_rvalid(b_ram_rvalid), .ram_rdata(b_ram_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_val(b_out_val), .out_x(b_out_x),
    .out_last(b_out_last), .err_oob(b_err));

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign a_out_ready = out_ready & ~sel;
  assign b_out_ready = out_ready & sel;
  assign in_ready    = sel ? b_in_ready  : a_in_ready;
  assign ram_valid   = sel ? b_ram_valid : a_ram_valid;
  assign ram_write   = sel ? b_ram_write : a_ram_write;
  assign ram_addr    = sel ? b_ram_addr  : a_ram_addr;
  assign out_valid   = sel ? b_out_valid : a_out_valid;
  assign out_val     = sel ? b_out_val   : a_out_val;
  assign out_x       = sel ? b_out_x     : a_out_x;
  assign out_last    = sel ? b_out_last  : a_out_last;
  assign err_oob     = sel ? b_err       : a_err;

  function automatic lanes_t ram_read(input idx_t a);
    lanes_t d;
    for (int j = 0; j < 4; j++) d[j] = (a[j] < LEN) ? xmem[a[j]] : 32'hDEAD_BEEF;
    return d;
  endfunction

  // Fixed-latency RAM models with no response backpressure.
  logic [LA-1:0] a_pv;
  lanes_t        a_pd [LA];
  logic [LB-1:0] b_pv;
  lanes_t        b_pd [LB];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pv <= '0;
      b_pv <= '0;
    end else begin
      a_pv[0] <= a_ram_valid;
      a_pd[0] <= ram_read(a_ram_addr);
      for (int s = 1; s < LA; s++) begin a_pv[s] <= a_pv[s-1]; a_pd[s] <= a_pd[s-1]; end
      b_pv[0] <= b_ram_valid;
      b_pd[0] <= ram_read(b_ram_addr);
      for (int s = 1; s < LB; s++) begin b_pv[s] <= b_pv[s-1]; b_pd[s] <= b_pd[s-1]; end
    end
  end
  assign a_ram_rvalid = a_pv[LA-1];
  assign a_ram_rdata  = a_pd[LA-1];
  assign b_ram_rvalid = b_pv[LB-1];
  assign b_ram_rdata  = b_pd[LB-1];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: every accepted beat becomes an expected output in arrival order.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      model_err = 1'b0;
      infl      = 0;
    end else begin
      chk("err_oob", err_oob, model_err);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out got out_valid=1 want no pending beat at %0t", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_val", out_val, mon_e.val);
          chk("sb_x", out_x, mon_e.x);
          chk("sb_last", out_last, mon_e.last);
        end
        pops++;
      end
      if (in_valid && in_ready) begin
        mon_e.val  = in_val;
        mon_e.last = in_last;
        for (int j = 0; j < 4; j++) begin
          mon_e.x[j] = (in_idx[j] < LEN) ? xmem[in_idx[j]] : 32'd0;
          if (in_idx[j] >= LEN) model_err = 1'b1;
        end
        sbq.push_back(mon_e);
        accepts++;
      end
      if (sel) begin
        infl = infl + int'(b_ram_valid) - int'(b_ram_rvalid);
        if (infl > max_infl) max_infl = infl;
        if (sbq.size() > max_out) max_out = sbq.size();
      end
    end
  end

  task automatic rand_beat(input int max_idx);
    for (int j = 0; j < 4; j++) begin
      in_idx[j] = 10'($urandom_range(0, max_idx));
      in_val[j] = $urandom;
    end
    in_last = 1'($urandom);
  endtask

  vec_t tv [5];
  int   base, acc, stalls, stale;
  logic took;

  initial begin
    for (int i = 0; i < LEN; i++) xmem[i] = 32'(i + 100);
    tv[0] = '{{10'd3, 10'd2, 10'd1, 10'd0}, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1,
              {32'd103, 32'd102, 32'd101, 32'd100}, {10'd3, 10'd2, 10'd1, 10'd0}, 1'b0};
    tv[1] = '{{10'd7, 10'd500, 10'd0, 10'd999}, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0,
              {32'd107, 32'd600, 32'd100, 32'd1099}, {10'd7, 10'd500, 10'd0, 10'd999}, 1'b0};
    tv[2] = '{{10'd42, 10'd42, 10'd42, 10'd42}, {32'h8000_0000, 32'd1, 32'd0, 32'hFFFF_FFFF}, 1'b1,
              {32'd142, 32'd142, 32'd142, 32'd142}, {10'd42, 10'd42, 10'd42, 10'd42}, 1'b0};
    tv[3] = '{{10'd7, 10'd1005, 10'd6, 10'd5}, {32'd6, 32'd7, 32'd8, 32'd9}, 1'b1,
              {32'd107, 32'd0, 32'd106, 32'd105}, {10'd7, 10'd0, 10'd6, 10'd5}, 1'b1};
    tv[4] = '{{10'd1023, 10'd998, 10'd1000, 10'd999}, {32'd1, 32'd1, 32'd1, 32'd1}, 1'b0,
              {32'd0, 32'd1098, 32'd0, 32'd1099}, {10'd0, 10'd998, 10'd0, 10'd999}, 1'b1};

    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_valid", ram_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_oob, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // Directed single beats: addressing, latency, alignment, out-of-range lanes.
    @(posedge clk); #1;
    for (int v = 0; v < 5; v++) begin
      in_valid = 1'b1;
      in_idx   = tv[v].idx;
      in_val   = tv[v].val;
      in_last  = tv[v].last;
      @(negedge clk);
      chk("tv_in_ready", in_ready, 1);
      chk("tv_ram_valid", ram_valid, 1);
      chk("tv_ram_write", ram_write, 0);
      chk("tv_ram_addr", ram_addr, tv[v].addr);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("tv_early_valid", out_valid, 0);
      @(negedge clk);
      chk("tv_out_valid", out_valid, 1);
      chk("tv_out_x", out_x, tv[v].x);
      chk("tv_out_val", out_val, tv[v].val);
      chk("tv_out_last", out_last, tv[v].last);
      chk("tv_err", err_oob, tv[v].err);
      @(posedge clk); #1;
    end

    // 64-beat stream at full rate.
    base = pops;
    stalls = 0;
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1;
      rand_beat(LEN - 1);
      @(negedge clk);
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_stalls", stalls, 0);
    repeat (2) @(negedge clk);
    #1 chk("stream_drained", pops - base, 64);

    // Consumer stalled: credit admits exactly FIFO_DEPTH beats.
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    took = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      if (took) rand_beat(LEN - 1);
      @(negedge clk);
      took = in_ready;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("full_accepted", acc, 4);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    base = pops;
    repeat (8) @(negedge clk);
    #1 chk("full_drained", pops - base, 4);

    // Reset with three beats buffered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      rand_beat(LEN - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_val", out_val, 0);
    chk("mid_rst_out_x", out_x, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_ram_valid", ram_valid, 0);
    chk("mid_rst_err", err_oob, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("post_rst_stale", stale, 0);

    // Deep-latency instance under random backpressure.
    @(posedge clk); #1;
    rst_n = 1'b0;
    sel = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = accepts;
    acc = pops;
    took = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_beat(1023);
      end
      out_ready = 1'($urandom);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("b_queue_empty", sbq.size(), 0);
    chk("b_all_out", pops - acc, accepts - base);
    chk("b_inflight_le3", max_infl <= 3, 1);
    chk("b_credit_le5", max_out <= 5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
